// File: rtl/pipe_run_ctrl_if.sv
// Control bundle between the debug/UART unit (master) and the pipeline run controller (slave).
interface pipe_run_ctrl_if #(
  parameter int CNT_BITS = 32
);
  logic                i_start;
  logic                i_mode;
  logic                i_step;
  logic                i_abort;
  logic                i_halt_fetched;
  logic                o_pipe_en;
  logic                o_flush;
  logic                o_busy;
  logic                o_done;
  logic [CNT_BITS-1:0] o_cycle_cnt;
  logic [2:0]          o_state;

  modport master (
    output i_start, i_mode, i_step, i_abort, i_halt_fetched,
    input  o_pipe_en, o_flush, o_busy, o_done, o_cycle_cnt, o_state
  );

  modport slave (
    input  i_start, i_mode, i_step, i_abort, i_halt_fetched,
    output o_pipe_en, o_flush, o_busy, o_done, o_cycle_cnt, o_state
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run controller for the pipelined MIPS datapath: gates the global pipeline enable,
// supports continuous and single-step execution, drains HALT and counts enabled cycles.
module pipe_run_ctrl #(
  parameter int PIPE_DEPTH = 5,
  parameter int CNT_BITS   = 32,
  parameter int DRAIN_BITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  pipe_run_ctrl_if.slave ctl
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLUSH      = 3'd1,
    RUN        = 3'd2,
    STEP_WAIT  = 3'd3,
    STEP_EXEC  = 3'd4,
    DRAIN_WAIT = 3'd5,
    DRAIN_EXEC = 3'd6,
    DONE       = 3'd7
  } state_t;

  localparam logic [DRAIN_BITS-1:0] DRAIN_LOAD = DRAIN_BITS'(PIPE_DEPTH - 1);
  localparam logic [DRAIN_BITS-1:0] DRAIN_ONE  = DRAIN_BITS'(1);

  state_t                state_q, state_d;
  logic [DRAIN_BITS-1:0] drain_q, drain_d;
  logic                  mode_q, mode_d;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  start_go;
  logic                  pipe_en;

  // Handshake: all i_* are level-sampled on the rising edge. i_start counts only in
  // IDLE/DONE, i_step only in the two WAIT states, and i_abort overrides everything.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    mode_d   = mode_q;
    start_go = 1'b0;
    if (ctl.i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (ctl.i_start) begin
            state_d  = FLUSH;
            mode_d   = ctl.i_mode;
            start_go = 1'b1;
          end
        end
        FLUSH: state_d = mode_q ? STEP_WAIT : RUN;
        RUN: begin
          if (ctl.i_halt_fetched) begin
            drain_d = DRAIN_LOAD;
            state_d = (PIPE_DEPTH == 1) ? DONE : DRAIN_EXEC;
          end
        end
        STEP_WAIT: begin
          if (ctl.i_step) state_d = STEP_EXEC;
        end
        STEP_EXEC: begin
          if (ctl.i_halt_fetched) begin
            drain_d = DRAIN_LOAD;
            state_d = (PIPE_DEPTH == 1) ? DONE : DRAIN_WAIT;
          end else begin
            state_d = STEP_WAIT;
          end
        end
        DRAIN_WAIT: begin
          if (ctl.i_step) state_d = DRAIN_EXEC;
        end
        DRAIN_EXEC: begin
          drain_d = drain_q - DRAIN_ONE;
          if (drain_q == DRAIN_ONE) state_d = DONE;
          else                      state_d = mode_q ? DRAIN_WAIT : DRAIN_EXEC;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
    end
  end

  assign pipe_en = (state_q == RUN) || (state_q == STEP_EXEC) || (state_q == DRAIN_EXEC);

  // The count survives abort so it can be read back; only a fresh start clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (start_go) begin
      cnt_q <= '0;
    end else if (pipe_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

  assign ctl.o_pipe_en   = pipe_en;
  assign ctl.o_flush     = (state_q == FLUSH);
  assign ctl.o_busy      = (state_q != IDLE) && (state_q != DONE);
  assign ctl.o_done      = (state_q == DONE);
  assign ctl.o_cycle_cnt = cnt_q;
  assign ctl.o_state     = state_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: vector table, directed corner sequences and
// randomized traffic compared against an abstract behavioural model.
module tb_pipe_run_ctrl;
  localparam int PIPE_DEPTH = 5;
  localparam int CNT_BITS   = 4;
  localparam int CNT_MAX    = (1 << CNT_BITS) - 1;

  logic clk;
  logic rst;

  pipe_run_ctrl_if #(.CNT_BITS(CNT_BITS)) ctl ();

  pipe_run_ctrl #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .CNT_BITS   (CNT_BITS),
    .DRAIN_BITS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // Abstract model: "active" run, pending flush, step arming, enabled cycles left after HALT.
  bit m_active, m_flush, m_done, m_mode, m_armed;
  int m_left;
  int m_cnt;

  typedef struct {
    logic       start, mode, step, abort, halt;
    logic [2:0] st;
    logic       en;
    logic [3:0] cnt;
    logic       done;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_en();
    return m_active && !m_flush && (!m_mode || m_armed);
  endfunction

  function automatic int model_state();
    if (!m_active)   return m_done ? 7 : 0;
    if (m_flush)     return 1;
    if (m_left < 0)  return m_mode ? (m_armed ? 4 : 3) : 2;
    return m_mode ? (m_armed ? 6 : 5) : 6;
  endfunction

  task automatic model_reset();
    m_active = 0; m_flush = 0; m_done = 0; m_mode = 0; m_armed = 0;
    m_left = -1; m_cnt = 0;
  endtask

  task automatic model_step(input bit s, input bit m, input bit st, input bit ab, input bit h);
    bit en;
    en = model_en();
    if (en && m_cnt < CNT_MAX) m_cnt++;
    if (ab) begin
      m_active = 0; m_flush = 0; m_done = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1; m_flush = 1; m_mode = m; m_done = 0;
        m_cnt = 0; m_left = -1; m_armed = 0;
      end
    end else if (m_flush) begin
      m_flush = 0;
    end else if (en) begin
      if (m_left < 0) begin
        if (h) m_left = PIPE_DEPTH - 1;
      end else begin
        m_left--;
      end
      if (m_left == 0) begin
        m_active = 0; m_done = 1;
      end
      m_armed = 0;
    end else if (st) begin
      m_armed = 1;
    end
  endtask

  task automatic check_model();
    chk("model_state", int'(ctl.o_state), model_state());
    chk("model_pipe_en", int'(ctl.o_pipe_en), int'(model_en()));
    chk("model_flush", int'(ctl.o_flush), int'(m_active && m_flush));
    chk("model_busy", int'(ctl.o_busy), int'(m_active));
    chk("model_done", int'(ctl.o_done), int'(m_done));
    chk("model_cnt", int'(ctl.o_cycle_cnt), m_cnt);
  endtask

  // driver: called at a falling edge, drives inputs for one rising edge, checks at the next falling edge
  task automatic tick(input bit s = 0, input bit m = 0, input bit st = 0,
                      input bit ab = 0, input bit h = 0);
    ctl.i_start = s; ctl.i_mode = m; ctl.i_step = st; ctl.i_abort = ab; ctl.i_halt_fetched = h;
    @(posedge clk);
    model_step(s, m, st, ab, h);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int n;
    bit gap;
    compared = 0;
    mismatched = 0;
    ctl.i_start = 0; ctl.i_mode = 0; ctl.i_step = 0; ctl.i_abort = 0; ctl.i_halt_fetched = 0;
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", int'(ctl.o_state), 0);
    chk("reset_pipe_en", int'(ctl.o_pipe_en), 0);
    chk("reset_flush", int'(ctl.o_flush), 0);
    chk("reset_busy", int'(ctl.o_busy), 0);
    chk("reset_done", int'(ctl.o_done), 0);
    chk("reset_cnt", int'(ctl.o_cycle_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // step-mode vector table: start, 3 steps, halt on 4th exec, 4 drain steps, extra step in DONE
    tbl[0]  = '{1, 1, 0, 0, 0, 3'd1, 0, 4'd0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 3'd3, 0, 4'd0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 3'd4, 1, 4'd0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 3'd3, 0, 4'd1, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 3'd4, 1, 4'd1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 3'd3, 0, 4'd2, 0};
    tbl[6]  = '{0, 0, 1, 0, 0, 3'd4, 1, 4'd2, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 3'd3, 0, 4'd3, 0};
    tbl[8]  = '{0, 0, 1, 0, 0, 3'd4, 1, 4'd3, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 3'd5, 0, 4'd4, 0};
    tbl[10] = '{0, 0, 1, 0, 0, 3'd6, 1, 4'd4, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 3'd5, 0, 4'd5, 0};
    tbl[12] = '{0, 0, 1, 0, 0, 3'd6, 1, 4'd5, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 3'd5, 0, 4'd6, 0};
    tbl[14] = '{0, 0, 1, 0, 0, 3'd6, 1, 4'd6, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 3'd5, 0, 4'd7, 0};
    tbl[16] = '{0, 0, 1, 0, 0, 3'd6, 1, 4'd7, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 3'd7, 0, 4'd8, 1};
    tbl[18] = '{0, 0, 1, 0, 0, 3'd7, 0, 4'd8, 1};
    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].start, tbl[i].mode, tbl[i].step, tbl[i].abort, tbl[i].halt);
      chk($sformatf("tbl%0d_state", i), int'(ctl.o_state), int'(tbl[i].st));
      chk($sformatf("tbl%0d_en", i), int'(ctl.o_pipe_en), int'(tbl[i].en));
      chk($sformatf("tbl%0d_cnt", i), int'(ctl.o_cycle_cnt), int'(tbl[i].cnt));
      chk($sformatf("tbl%0d_done", i), int'(ctl.o_done), int'(tbl[i].done));
    end

    // continuous run, HALT during the 10th enabled cycle
    tick(.s(1), .m(0));
    chk("cont_flush", int'(ctl.o_flush), 1);
    tick();
    n = 0; gap = 0;
    for (int i = 0; i < 40 && !ctl.o_done; i++) begin
      if (ctl.o_pipe_en) n++;
      else gap = 1;
      tick(.h(n == 10));
    end
    chk("cont_en_cycles", n, 14);
    chk("cont_en_gap", int'(gap), 0);
    chk("cont_done", int'(ctl.o_done), 1);
    chk("cont_busy", int'(ctl.o_busy), 0);
    chk("cont_cnt", int'(ctl.o_cycle_cnt), 14);
    chk("cont_state", int'(ctl.o_state), 7);

    // abort mid-drain: HALT on enabled cycle 3, abort two cycles later
    tick(.s(1), .m(0));
    tick();
    n = 1;
    for (int i = 0; i < 4; i++) begin
      tick(.h(n == 3));
      n++;
    end
    tick(.ab(1));
    chk("abort_state", int'(ctl.o_state), 0);
    chk("abort_en", int'(ctl.o_pipe_en), 0);
    chk("abort_done", int'(ctl.o_done), 0);
    chk("abort_cnt", int'(ctl.o_cycle_cnt), 5);

    // saturation
    tick(.s(1), .m(0));
    tick();
    repeat (20) tick();
    chk("sat_cnt20", int'(ctl.o_cycle_cnt), CNT_MAX);
    repeat (3) tick();
    chk("sat_cnt_hold", int'(ctl.o_cycle_cnt), CNT_MAX);

    // start ignored while busy, then start in DONE with step mode
    tick(.s(1), .m(1));
    chk("busy_start_state", int'(ctl.o_state), 2);
    tick(.ab(1));
    tick(.s(1), .m(0));
    tick();
    tick(); tick();
    tick(.s(1), .m(1));
    chk("run_start_ignored", int'(ctl.o_state), 2);
    chk("run_start_cnt", int'(ctl.o_cycle_cnt), 3);
    tick(.h(1));
    repeat (4) tick();
    chk("prio_done", int'(ctl.o_state), 7);
    tick(.s(1), .m(1));
    chk("done_start_state", int'(ctl.o_state), 1);
    chk("done_start_cnt", int'(ctl.o_cycle_cnt), 0);
    tick();
    chk("done_start_step_wait", int'(ctl.o_state), 3);
    tick(.ab(1));
    tick(.s(1), .ab(1));
    chk("start_abort_idle", int'(ctl.o_state), 0);

    // async reset between edges while running
    tick(.s(1), .m(0));
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("areset_state", int'(ctl.o_state), 0);
    chk("areset_en", int'(ctl.o_pipe_en), 0);
    chk("areset_busy", int'(ctl.o_busy), 0);
    chk("areset_cnt", int'(ctl.o_cycle_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      tick(.s($urandom_range(0, 7) == 0), .m($urandom_range(0, 1) == 1),
           .st($urandom_range(0, 1) == 1), .ab($urandom_range(0, 39) == 0),
           .h($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
Run controller for the pipelined MIPS datapath. Gates the single pipeline-enable seen by every stage register and supports continuous and single-step execution. Issues a one-cycle pipeline flush at start and detects a HALT instruction at fetch. Drains the remaining stages so HALT retires, then reports completion with a count of enabled cycles. Sits between the debug/UART unit and datapath_pipe.

Parameters:
PIPE_DEPTH, 5, number of pipeline stages HALT must traverse (≥1)
CNT_BITS, 32, width of enabled-cycle counter
DRAIN_BITS, 3, width of drain counter (≥ clog2(PIPE_DEPTH))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
i_start  input  1  begin execution; honoured only in IDLE or DONE
i_mode  input  1  sampled with i_start: 0 = continuous, 1 = step
i_step  input  1  advance one pipeline cycle (step mode only)
i_abort  input  1  return to IDLE from any state
i_halt_fetched  input  1  fetch stage holds HALT this cycle
o_pipe_en  output  1  enable for all pipeline registers
o_flush  output  1  synchronous clear for pipeline registers
o_busy  output  1  high in every state except IDLE and DONE
o_done  output  1  HALT retired; held until next start or abort
o_cycle_cnt  output  CNT_BITS  number of cycles with o_pipe_en=1 since last start
o_state  output  3  current state encoding, for debug readback

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all 1-bit outputs 0, o_cycle_cnt=0, drain counter 0, latched mode 0.
- States and encoding: IDLE=0, FLUSH=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, DRAIN_WAIT=5, DRAIN_EXEC=6, DONE=7.
- o_pipe_en=1 only in RUN, STEP_EXEC and DRAIN_EXEC. It is decoded from registered state.
- o_flush=1 only in FLUSH.
- IDLE/DONE + i_start: go to FLUSH. Latch i_mode. Clear o_cycle_cnt and o_done.
- FLUSH (exactly 1 cycle): go to RUN if mode=0, else STEP_WAIT.
- RUN: if i_halt_fetched, go to DRAIN_EXEC with drain=PIPE_DEPTH-1. If PIPE_DEPTH=1, go straight to DONE.
- STEP_WAIT: i_step goes to STEP_EXEC. o_pipe_en stays 0 while waiting.
- STEP_EXEC (1 cycle): if i_halt_fetched, load drain as in RUN and go to DRAIN_WAIT. Otherwise go to STEP_WAIT.
- DRAIN_EXEC, continuous mode:
  - Each cycle decrements drain.
  - If drain=1 at the edge, go to DONE. Otherwise stay in DRAIN_EXEC.
- DRAIN_EXEC, step mode:
  - Decrements drain.
  - If drain=1, go to DONE. Otherwise go to DRAIN_WAIT.
- DRAIN_WAIT: i_step goes to DRAIN_EXEC.
- i_halt_fetched is ignored outside RUN and STEP_EXEC.
- o_cycle_cnt increments on every edge where o_pipe_en=1. It saturates at all-ones and never wraps.
- i_abort has top priority in every state. Next state is IDLE and o_done is cleared. o_cycle_cnt holds its value for readback. i_start/i_step in the same cycle are ignored.
- i_start while o_busy=1 is ignored, and so is i_mode.
- i_step is ignored outside STEP_WAIT and DRAIN_WAIT. A held i_step advances one cycle per two clocks (WAIT→EXEC→WAIT).
- o_done=1 exactly in DONE.
- rst asserted mid-run: everything returns to reset values immediately, without waiting for the clock.

Test Plan:
- Continuous run (PIPE_DEPTH=5): rst release, i_start=1 with i_mode=0 → 1 cycle of o_flush. Pulse i_halt_fetched during the 10th enabled cycle → o_pipe_en high for 14 consecutive cycles, then o_done=1, o_busy=0, o_cycle_cnt=14, o_state=7.
- Step mode: i_start with i_mode=1, pulse i_step 3 times, 4th step with i_halt_fetched=1, then 4 more steps → 8 single-cycle o_pipe_en pulses, never consecutive. o_done rises after the 8th, o_cycle_cnt=8. Extra i_step in DONE → no effect.
- Abort mid-drain: continuous run, HALT at enabled cycle 3, i_abort 2 cycles later → o_state=0 next cycle, o_pipe_en=0, o_done=0, o_cycle_cnt=5 held.
- Saturation (CNT_BITS=4): continuous run, no HALT for 20 cycles → o_cycle_cnt reaches 15 and stays 15.
- Async reset: drive rst=0 between clock edges while in RUN → outputs zero before the next edge, o_state=0.
- Start priority: i_start during RUN → ignored, count continues. i_start in DONE with i_mode=1 → FLUSH, o_cycle_cnt=0, then STEP_WAIT. i_start+i_abort together in IDLE → stays IDLE.
